// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus independent per-bit debounce, change strobe.
// Optional sticky per-bit change mask (evt_o) built when SW_DEBOUNCE_EVT_EN is defined.
module sw_debounce_bit #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 2
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic i_raw,
   output logic o_lvl,
   output logic o_tgl
);
   logic             r_sync1, r_sync2, r_lvl;
   logic [CNT_W-1:0] r_cnt;
   logic             w_mis, w_done;

   assign w_mis  = r_sync2 ^ r_lvl;
   assign w_done = w_mis && (r_cnt == CNT_W'(DB_CYCLES-1));

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_lvl   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         // Any brief return to agreement restarts the count.
         if (!w_mis) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_lvl <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_lvl = r_lvl;
   assign o_tgl = w_done;
endmodule

module sw_debounce #(
   parameter int N_SW      = 10,
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = $clog2(DB_CYCLES)
) (
   input  logic            clk_clk,
   input  logic            reset_reset_n,
   input  logic [N_SW-1:0] sw_raw_i,
   output logic [N_SW-1:0] sw_o,
   output logic            sw_chg_o,
   output logic [N_SW-1:0] evt_o,
   input  logic            evt_clr_i
);
   logic [N_SW-1:0] w_lvl, w_tgl;
   logic            r_chg;

   for (genvar g = 0; g < N_SW; g++) begin : g_bit
      sw_debounce_bit #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_bit (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .i_raw         (sw_raw_i[g]),
         .o_lvl         (w_lvl[g]),
         .o_tgl         (w_tgl[g])
      );
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_chg <= 1'b0;
      else                r_chg <= |w_tgl;
   end

   assign sw_o     = w_lvl;
   assign sw_chg_o = r_chg;

`ifdef SW_DEBOUNCE_EVT_EN
   logic [N_SW-1:0] r_evt;

   // Set beats clear on the same edge so no toggle is ever lost.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_evt <= '0;
      else                r_evt <= (evt_clr_i ? '0 : r_evt) | w_tgl;
   end

   assign evt_o = r_evt;
`else
   logic w_unused_clr;
   assign w_unused_clr = evt_clr_i;
   assign evt_o        = '0;
`endif
endmodule
